// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// Used by the ALU, the ALU command driver and the round-control sequencer.
//   alu_op_t    : 2-bit ALU op code; all four encodings are legal.
//   drv_state_t : command-driver FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_OR  = 2'b01,
    ALU_XOR = 2'b10,
    ALU_ADD = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    EXEC   = 2'd1,
    RESP   = 2'd2
  } drv_state_t;

endpackage

// File: rtl/alu_cmd_driver.sv
// Initiator side of the combinational ALU port.
// Accepts (op, operand, last) commands over valid/ready and drives one ALU
// operation per command. The ALU result is chained back into an accumulator
// that feeds operand_a. After the last command of a chain, the final value,
// zero flag and op/zero-hit counts are returned over a valid/ready response.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready   command handshake; cmd_op, cmd_operand, cmd_last payload
//   operand_a/b, alu_op   to the external ALU
//   result, zero      from the external ALU (combinational)
//   rsp_valid/ready   response handshake
//   rsp_result, rsp_zero, rsp_op_count, rsp_zero_count   response payload
//
// Every output is a flop or a decode of the state register.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_operand,
  input  logic               cmd_last,
  output logic [WIDTH-1:0]   operand_a,
  output logic [WIDTH-1:0]   operand_b,
  output logic [1:0]         alu_op,
  input  logic [WIDTH-1:0]   result,
  input  logic               zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_zero,
  output logic [COUNT_W-1:0] rsp_op_count,
  output logic [COUNT_W-1:0] rsp_zero_count
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  drv_state_t         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   operand_b_q, operand_b_d;
  alu_op_t            alu_op_q, alu_op_d;
  logic               zero_q, zero_d;
  logic               last_q, last_d;
  logic [COUNT_W-1:0] op_count_q, op_count_d;
  logic [COUNT_W-1:0] zero_count_q, zero_count_d;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    operand_b_d  = operand_b_q;
    alu_op_d     = alu_op_q;
    zero_d       = zero_q;
    last_d       = last_q;
    op_count_d   = op_count_q;
    zero_count_d = zero_count_q;
    case (state_q)
      ACCEPT: begin
        if (cmd_valid) begin
          alu_op_d    = alu_op_t'(cmd_op);
          operand_b_d = cmd_operand;
          last_d      = cmd_last;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        acc_d  = result;
        zero_d = zero;
        if (op_count_q != CNT_MAX) begin
          op_count_d = op_count_q + 1'b1;
        end
        if (zero && (zero_count_q != CNT_MAX)) begin
          zero_count_d = zero_count_q + 1'b1;
        end
        state_d = last_q ? RESP : ACCEPT;
      end
      RESP: begin
        if (rsp_ready) begin
          acc_d        = '0;
          zero_d       = 1'b0;
          op_count_d   = '0;
          zero_count_d = '0;
          state_d      = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCEPT;
      acc_q       <= '0;
      operand_b_q <= '0;
      alu_op_q    <= ALU_AND;
      zero_q      <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      operand_b_q <= operand_b_d;
      alu_op_q    <= alu_op_d;
      zero_q      <= zero_d;
      last_q      <= last_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count_q <= '0;
    else        op_count_q <= op_count_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zero_count_q <= '0;
    else        zero_count_q <= zero_count_d;
  end

  // The accumulator only changes in EXEC and on response hand-off, so it can
  // feed both the ALU and the response payload directly.
  assign cmd_ready      = (state_q == ACCEPT);
  assign rsp_valid      = (state_q == RESP);
  assign operand_a      = acc_q;
  assign operand_b      = operand_b_q;
  assign alu_op         = alu_op_q;
  assign rsp_result     = acc_q;
  assign rsp_zero       = zero_q;
  assign rsp_op_count   = op_count_q;
  assign rsp_zero_count = zero_count_q;

endmodule
